// File: rtl/dyn_adder_arbiter.sv
// Two-requester arbiter in front of a shared, variable-latency adder.
// Define ADDER_ARB_ROUND_ROBIN_EN for round-robin grant; default is fixed priority (req0 wins).
module dyn_adder_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic [WIDTH-1:0] adr_a,
    output logic [WIDTH-1:0] adr_b,
    output logic             adr_cin,
    output logic             adr_first,
    input  logic [WIDTH-1:0] adr_p,
    input  logic [WIDTH-1:0] adr_sum,
    input  logic             adr_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout
);

    localparam int unsigned Q = WIDTH / 4;

    typedef enum logic [1:0] {StIdle, StLaunch, StWait, StResp} state_e;

    state_e           state_q;
    logic [1:0]       cnt_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic             op_cin_q;
    logic             id_q;
    logic             grant;
    logic [3:1]       brk;
    logic [1:0]       w_m1;
    logic             idle;
    logic             unused_p;

`ifdef ADDER_ARB_ROUND_ROBIN_EN
    logic last_grant_q;

    always_comb begin
        grant = ~req0_valid;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end
    end
`else
    assign grant = ~req0_valid;
`endif

    // Readies are gated by reset so nothing handshakes while reset is held.
    assign idle       = (state_q == StIdle) && rst_n;
    assign req0_ready = idle && req0_valid && !grant;
    assign req1_ready = idle && req1_valid && grant;

    assign adr_a   = op_a_q;
    assign adr_b   = op_b_q;
    assign adr_cin = op_cin_q;

    // A quarter boundary breaks the carry chain unless both bits around it propagate.
    assign brk[1] = ~(adr_p[Q] & adr_p[Q-1]);
    assign brk[2] = ~(adr_p[2*Q] & adr_p[2*Q-1]);
    assign brk[3] = ~(adr_p[3*Q] & adr_p[3*Q-1]);
    assign unused_p = ^adr_p;

    // Longest unbroken run of quarters, minus one.
    always_comb begin
        unique case (brk)
            3'b000:          w_m1 = 2'd3;
            3'b001, 3'b100:  w_m1 = 2'd2;
            3'b111:          w_m1 = 2'd0;
            default:         w_m1 = 2'd1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= 2'd0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            op_cin_q  <= 1'b0;
            id_q      <= 1'b0;
            adr_first <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
`ifdef ADDER_ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req0_ready || req1_ready) begin
                        op_a_q    <= grant ? req1_a : req0_a;
                        op_b_q    <= grant ? req1_b : req0_b;
                        op_cin_q  <= grant ? req1_cin : req0_cin;
                        id_q      <= grant;
                        adr_first <= 1'b1;
                        state_q   <= StLaunch;
`ifdef ADDER_ARB_ROUND_ROBIN_EN
                        last_grant_q <= grant;
`endif
                    end
                end
                StLaunch: begin
                    adr_first <= 1'b0;
                    cnt_q     <= w_m1;
                    state_q   <= StWait;
                end
                StWait: begin
                    if (cnt_q == 2'd0) begin
                        rsp_sum   <= adr_sum;
                        rsp_cout  <= adr_cout;
                        rsp_id    <= id_q;
                        rsp_valid <= 1'b1;
                        state_q   <= StResp;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dyn_adder_arbiter.sv
// Directed bench for dyn_adder_arbiter with a behavioural shared adder.
module tb_dyn_adder_arbiter;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req1_valid, req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             req0_cin, req1_cin;
    logic [WIDTH-1:0] adr_a, adr_b, adr_p, adr_sum;
    logic             adr_cin, adr_first, adr_cout;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_cout;
    logic [WIDTH-1:0] rsp_sum;

    int n_tests = 0;
    int n_fail  = 0;

    dyn_adder_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .adr_a(adr_a), .adr_b(adr_b), .adr_cin(adr_cin), .adr_first(adr_first),
        .adr_p(adr_p), .adr_sum(adr_sum), .adr_cout(adr_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
    );

    always #5 clk = ~clk;

    // Shared adder: propagate vector plus a settled sum.
    always_comb begin
        adr_p = adr_a ^ adr_b;
        {adr_cout, adr_sum} = {1'b0, adr_a} + {1'b0, adr_b} + {{WIDTH{1'b0}}, adr_cin};
    end

    typedef struct {
        logic             id;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        int               w;
        logic [WIDTH-1:0] sum;
        logic             cout;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        int t, first_cnt, first_at;
        if (v.id) begin
            req1_valid = 1'b1; req1_a = v.a; req1_b = v.b; req1_cin = v.cin;
        end else begin
            req0_valid = 1'b1; req0_a = v.a; req0_b = v.b; req0_cin = v.cin;
        end
        #1;
        check("granted_ready", v.id ? req1_ready : req0_ready, 1);
        check("other_ready", v.id ? req0_ready : req1_ready, 0);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        t = 1; first_cnt = 0; first_at = 0;
        while (!rsp_valid && t < 20) begin
            if (adr_first) begin
                first_cnt++;
                first_at = t;
            end
            @(posedge clk);
            #1;
            t++;
        end
        check("latency", t, 2 + v.w);
        check("first_count", first_cnt, 1);
        check("first_cycle", first_at, 1);
        check("rsp_sum", rsp_sum, v.sum);
        check("rsp_cout", rsp_cout, v.cout);
        check("rsp_id", rsp_id, v.id);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("rsp_valid_drop", rsp_valid, 0);
    endtask

    initial begin
        int seen, t;
        logic [3:0] ids;
        logic both_ready;
        vec_t v;

        vecs[0] = '{1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1, 32'h0000_0100, 1'b0};
        vecs[1] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 4, 32'h0000_0000, 1'b1};
        vecs[2] = '{1'b0, 32'h0000_FFFF, 32'h0000_0000, 1'b0, 2, 32'h0000_FFFF, 1'b0};
        vecs[3] = '{1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1, 32'h2345_6789, 1'b0};
        vecs[4] = '{1'b0, 32'h0181_8000, 32'h0000_0000, 1'b1, 3, 32'h0181_8001, 1'b0};
        vecs[5] = '{1'b1, 32'h0001_8180, 32'h0000_0000, 1'b0, 3, 32'h0001_8180, 1'b0};
        vecs[6] = '{1'b0, 32'h0180_0180, 32'h0000_0000, 1'b0, 2, 32'h0180_0180, 1'b0};
        vecs[7] = '{1'b1, 32'h0001_8000, 32'h0000_0000, 1'b0, 2, 32'h0001_8000, 1'b0};
        vecs[8] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1, 32'h0000_0000, 1'b1};

        // Reset with random, valid-asserted inputs.
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            req0_a = $urandom; req0_b = $urandom; req0_cin = 1'($urandom);
            req1_a = $urandom; req1_b = $urandom; req1_cin = 1'($urandom);
            @(posedge clk);
            #1;
            check("reset_readies", {req0_ready, req1_ready}, 0);
            check("reset_outs", {adr_a, adr_b, adr_cin, adr_first, rsp_valid, rsp_id, rsp_cout}, 0);
            check("reset_sum", rsp_sum, 0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req0_cin = 1'b0;
        req1_a = '0; req1_b = '0; req1_cin = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Both requesters always valid: grant order depends on arbitration mode.
        do_reset();
        req0_a = 32'd1; req0_b = 32'd1; req0_cin = 1'b0;
        req1_a = 32'd2; req1_b = 32'd2; req1_cin = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        seen = 0; t = 0; ids = '0; both_ready = 1'b0;
        while (seen < 4 && t < 60) begin
            #1;
            if (req0_ready && req1_ready) both_ready = 1'b1;
            @(posedge clk);
            #1;
            t++;
            if (rsp_valid) begin
                ids[seen] = rsp_id;
                check("rr_sum", rsp_sum, rsp_id ? 32'd4 : 32'd2);
                seen++;
                if (seen == 4) begin
                    req0_valid = 1'b0; req1_valid = 1'b0;
                end
            end
        end
        check("rr_seen", seen, 4);
        check("rr_both_ready", both_ready, 0);
`ifdef ADDER_ARB_ROUND_ROBIN_EN
        check("rr_order", ids, 4'b1010);
`else
        check("rr_order", ids, 4'b0000);
`endif
        @(posedge clk);
        #1 rsp_ready = 1'b0;

        // Response back-pressure with a held-off request from req1.
        req0_valid = 1'b1; req0_a = 32'h0000_00FF; req0_b = 32'h1; req0_cin = 1'b0;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_cin = 1'b0;
        t = 0;
        while (!rsp_valid && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("stall_resp_seen", rsp_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall_valid", rsp_valid, 1);
            check("stall_sum", rsp_sum, 32'h0000_0100);
            check("stall_id", rsp_id, 0);
            check("stall_readies", {req0_ready, req1_ready}, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("heldoff_ready", req1_ready, 1);
        check("resp_cleared", rsp_valid, 0);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        t = 0;
        while (!rsp_valid && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("heldoff_sum", rsp_sum, 32'd7);
        check("heldoff_id", rsp_id, 1);
        @(posedge clk);
        #1 rsp_ready = 1'b0;

        // Reset in WAIT abandons the add.
        req1_valid = 1'b1; req1_a = 32'hFFFF_FFFF; req1_b = '0; req1_cin = 1'b1;
        @(posedge clk);
        #1 req1_valid = 1'b0;
        @(posedge clk);
        #1;
        check("mid_in_wait", adr_a, 32'hFFFF_FFFF);
        rst_n = 1'b0;
        #1;
        check("mid_reset_adr", {adr_a, adr_cin, adr_first}, 0);
        check("mid_reset_rsp", {rsp_valid, rsp_id, rsp_cout, rsp_sum}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen++;
        end
        check("no_resp_after_reset", seen, 0);
        rsp_ready = 1'b0;
        do_reset();
        v = vecs[0];
        run_vec(v);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
